// File: rtl/step_clk_ctrl_if.sv
// Board-side controls and CPU clocking outputs of the step/run clock controller.
interface step_clk_ctrl_if;
    logic        STEP;
    logic        btn_step;
    logic        CPUClk;
    logic        nCPUClk;
    logic        cpu_en;
    logic        step_busy;
    logic [31:0] cyc_cnt;

    modport master (
        output STEP, btn_step,
        input  CPUClk, nCPUClk, cpu_en, step_busy, cyc_cnt
    );

    modport slave (
        input  STEP, btn_step,
        output CPUClk, nCPUClk, cpu_en, step_busy, cyc_cnt
    );
endinterface

// File: rtl/step_clk_ctrl.sv
// CPU clock generator: free-running divided clock in run mode, one period per debounced press in step mode.
// Inputs see +2 clk sync latency, presses/releases +DB_CNT; no backpressure, all clock outputs registered.
module step_clk_ctrl #(
    parameter int              RUN_DIV = 2,
    parameter int              DB_W    = 20,
    parameter logic [DB_W-1:0] DB_CNT  = 20'd1_000_000
) (
    input  logic            clk,
    input  logic            rst,
    step_clk_ctrl_if.slave  cpu_if
);
    typedef enum logic [2:0] {
        S_RUN, S_IDLE, S_PULSE_HI, S_PULSE_LO, S_WAIT_REL
    } state_t;

    localparam int                HALF      = 1 << (RUN_DIV - 1);
    localparam logic [RUN_DIV-1:0] DIV_LAST  = '1;
    localparam logic [RUN_DIV-1:0] HALF_VAL  = RUN_DIV'(HALF);
    localparam logic [RUN_DIV-1:0] HALF_LAST = RUN_DIV'(HALF - 1);
    localparam logic [DB_W-1:0]    DB_LAST   = DB_CNT - 1'b1;

    state_t             r_state, w_state_nxt;
    logic               r_step_s1, r_step_s2, r_btn_s1, r_btn_s2;
    logic [RUN_DIV-1:0] r_div_cnt, w_div_nxt;
    logic [DB_W-1:0]    r_db_cnt, w_db_nxt;
    logic               r_cpu_clk, r_ncpu_clk, r_cpu_en;
    logic               w_cpu_clk_nxt, w_cpu_en_nxt;
    logic [31:0]        r_cyc_cnt;
    logic               w_db_in, w_db_hit, w_div_wrap, w_half_done;

    // Debounce counts the level we are waiting for: pressed in IDLE, released in WAIT_REL.
    assign w_db_in     = (r_state == S_WAIT_REL) ? ~r_btn_s2 : r_btn_s2;
    assign w_db_hit    = w_db_in && (r_db_cnt == DB_LAST);
    assign w_div_wrap  = (r_div_cnt == DIV_LAST);
    assign w_half_done = (r_div_cnt == HALF_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:      if (w_div_wrap && r_step_s2) w_state_nxt = S_IDLE;
            S_IDLE:     if (!r_step_s2)              w_state_nxt = S_RUN;
                        else if (w_db_hit)           w_state_nxt = S_PULSE_HI;
            S_PULSE_HI: if (w_half_done)             w_state_nxt = S_PULSE_LO;
            S_PULSE_LO: if (w_half_done)             w_state_nxt = S_WAIT_REL;
            S_WAIT_REL: if (w_db_hit)                w_state_nxt = S_IDLE;
            default:                                 w_state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        w_div_nxt     = '0;
        w_db_nxt      = '0;
        w_cpu_clk_nxt = 1'b0;
        w_cpu_en_nxt  = 1'b0;
        case (r_state)
            S_RUN: begin
                // Wrap lands on 0 with the clock low, so a switch to IDLE here never truncates a phase.
                w_div_nxt     = r_div_cnt + 1'b1;
                w_cpu_clk_nxt = w_div_nxt[RUN_DIV-1];
                w_cpu_en_nxt  = (w_div_nxt == HALF_VAL);
            end
            S_IDLE: begin
                if (r_step_s2 && w_db_hit) begin
                    w_cpu_clk_nxt = 1'b1;
                    w_cpu_en_nxt  = 1'b1;
                end else if (r_step_s2 && w_db_in) begin
                    w_db_nxt = r_db_cnt + 1'b1;
                end
            end
            S_PULSE_HI: begin
                if (!w_half_done) begin
                    w_div_nxt     = r_div_cnt + 1'b1;
                    w_cpu_clk_nxt = 1'b1;
                end
            end
            S_PULSE_LO: begin
                if (!w_half_done) w_div_nxt = r_div_cnt + 1'b1;
            end
            S_WAIT_REL: begin
                if (w_db_in && !w_db_hit) w_db_nxt = r_db_cnt + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_step_s1  <= 1'b0;
            r_step_s2  <= 1'b0;
            r_btn_s1   <= 1'b0;
            r_btn_s2   <= 1'b0;
            r_div_cnt  <= '0;
            r_db_cnt   <= '0;
            r_cpu_clk  <= 1'b0;
            r_ncpu_clk <= 1'b1;
            r_cpu_en   <= 1'b0;
            r_cyc_cnt  <= '0;
        end else begin
            r_step_s1  <= cpu_if.STEP;
            r_step_s2  <= r_step_s1;
            r_btn_s1   <= cpu_if.btn_step;
            r_btn_s2   <= r_btn_s1;
            r_div_cnt  <= w_div_nxt;
            r_db_cnt   <= w_db_nxt;
            r_cpu_clk  <= w_cpu_clk_nxt;
            r_ncpu_clk <= ~w_cpu_clk_nxt;
            r_cpu_en   <= w_cpu_en_nxt;
            if (w_cpu_en_nxt) r_cyc_cnt <= r_cyc_cnt + 32'd1;
        end
    end

    assign cpu_if.CPUClk    = r_cpu_clk;
    assign cpu_if.nCPUClk   = r_ncpu_clk;
    assign cpu_if.cpu_en    = r_cpu_en;
    assign cpu_if.cyc_cnt   = r_cyc_cnt;
    assign cpu_if.step_busy = (r_state == S_PULSE_HI) || (r_state == S_PULSE_LO) ||
                              (r_state == S_WAIT_REL);
endmodule

// File: tb/tb_step_clk_ctrl.sv
// Directed bench for step_clk_ctrl with RUN_DIV=2, DB_CNT=4; per-edge traces compared against hand-derived vectors.
module tb_step_clk_ctrl;
    logic clk = 1'b0;
    logic rst;

    step_clk_ctrl_if u_if();

    step_clk_ctrl #(
        .RUN_DIV (2),
        .DB_W    (20),
        .DB_CNT  (20'd4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .cpu_if (u_if)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_cyc;
    logic [63:0] obs_clk, obs_nclk, obs_en, obs_busy;
    logic [63:0] exp_clk, exp_en, exp_busy;
    logic [63:0] mask;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Trace bit i holds the outputs seen just after the (i+1)-th edge; inputs for that edge are bit i of the patterns.
    task automatic run_seq(input int n, input logic [63:0] btn_pat, input logic [63:0] step_pat);
        obs_clk  = '0;
        obs_nclk = '0;
        obs_en   = '0;
        obs_busy = '0;
        for (int i = 0; i < n; i++) begin
            u_if.btn_step = btn_pat[i];
            u_if.STEP     = step_pat[i];
            @(posedge clk);
            #1;
            obs_clk[i]  = u_if.CPUClk;
            obs_nclk[i] = u_if.nCPUClk;
            obs_en[i]   = u_if.cpu_en;
            obs_busy[i] = u_if.step_busy;
        end
    endtask

    task automatic check_trace(input string tag);
        check({tag, "_clk"},  obs_clk,  exp_clk);
        check({tag, "_en"},   obs_en,   exp_en);
        check({tag, "_busy"}, obs_busy, exp_busy);
    endtask

    initial begin
        rst           = 1'b0;
        u_if.STEP     = 1'b0;
        u_if.btn_step = 1'b0;
        #12;
        check("rst_clk",  {63'd0, u_if.CPUClk},    64'd0);
        check("rst_nclk", {63'd0, u_if.nCPUClk},   64'd1);
        check("rst_en",   {63'd0, u_if.cpu_en},    64'd0);
        check("rst_busy", {63'd0, u_if.step_busy}, 64'd0);
        check("rst_cyc",  {32'd0, u_if.cyc_cnt},   64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Run mode: 0,0,1,1 pattern, rise every 4 clk
        run_seq(40, 64'd0, 64'd0);
        exp_clk = '0; exp_en = '0; exp_busy = '0;
        for (int i = 0; i < 40; i++) begin
            exp_clk[i] = ((i + 1) % 4) >= 2;
            exp_en[i]  = ((i + 1) % 4) == 2;
        end
        mask = (64'd1 << 40) - 64'd1;
        check_trace("run");
        check("run_nclk", obs_nclk, ~exp_clk & mask);
        check("run_cyc10", {32'd0, u_if.cyc_cnt}, 64'd10);
        exp_cyc = 32'd10;

        // STEP raised at div_cnt=2: high phase finishes, one more period passes the synchroniser, then IDLE
        run_seq(20, 64'd0, 64'hF_FFFC);
        exp_clk = 64'h66; exp_en = 64'h22; exp_busy = 64'd0;
        check_trace("to_idle");
        exp_cyc += 32'd2;
        check("to_idle_cyc", {32'd0, u_if.cyc_cnt}, {32'd0, exp_cyc});

        // Press held 20 clk: one 2-clk pulse after sync+debounce, busy until debounced release
        run_seq(32, 64'hF_FFFF, '1);
        exp_clk = 64'h60; exp_en = 64'h20; exp_busy = 64'h01FF_FFE0;
        check_trace("press");
        exp_cyc += 32'd1;
        check("press_cyc", {32'd0, u_if.cyc_cnt}, {32'd0, exp_cyc});

        // Bounce 1,1,1,0: never 4 stable cycles
        run_seq(40, 64'h7777_7777, '1);
        exp_clk = '0; exp_en = '0; exp_busy = '0;
        check_trace("bounce");
        check("bounce_cyc", {32'd0, u_if.cyc_cnt}, {32'd0, exp_cyc});

        // STEP dropped during WAIT_REL: stay low until debounced release, then RUN from div_cnt=0
        run_seq(40, 64'h7FFF, 64'h3FF);
        exp_clk = 64'h60; exp_en = 64'h20; exp_busy = '0;
        for (int i = 5; i < 20; i++) exp_busy[i] = 1'b1;
        for (int i = 21; i < 40; i++) begin
            exp_clk[i] = ((i + 1 - 22) % 4) >= 2;
            exp_en[i]  = ((i + 1 - 22) % 4) == 2;
        end
        check_trace("step_off");
        exp_cyc += 32'd6;
        check("step_off_cyc", {32'd0, u_if.cyc_cnt}, {32'd0, exp_cyc});

        // Back to IDLE, preload counter at all-ones, next pulse wraps it
        run_seq(12, 64'd0, '1);
        force dut.r_cyc_cnt = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.r_cyc_cnt;
        #1;
        check("preload_cyc", {32'd0, u_if.cyc_cnt}, 64'hFFFF_FFFF);
        run_seq(32, 64'hF_FFFF, '1);
        exp_clk = 64'h60; exp_en = 64'h20; exp_busy = 64'h01FF_FFE0;
        check_trace("wrap");
        exp_cyc = 32'hFFFF_FFFF;
        exp_cyc += 32'd1;
        check("wrap_cyc", {32'd0, u_if.cyc_cnt}, {32'd0, exp_cyc});

        // Asynchronous reset in the first cycle of PULSE_HI
        run_seq(6, 64'h3F, '1);
        check("pre_rst_hi", obs_clk, 64'h20);
        check("pre_rst_cyc", {32'd0, u_if.cyc_cnt}, 64'd1);
        rst = 1'b0;
        #1;
        check("arst_clk",  {63'd0, u_if.CPUClk},    64'd0);
        check("arst_nclk", {63'd0, u_if.nCPUClk},   64'd1);
        check("arst_en",   {63'd0, u_if.cpu_en},    64'd0);
        check("arst_busy", {63'd0, u_if.step_busy}, 64'd0);
        check("arst_cyc",  {32'd0, u_if.cyc_cnt},   64'd0);
        u_if.STEP     = 1'b0;
        u_if.btn_step = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_seq(8, 64'd0, 64'd0);
        exp_clk = 64'h66; exp_en = 64'h22; exp_busy = '0;
        check_trace("post_rst");
        check("post_rst_cyc", {32'd0, u_if.cyc_cnt}, 64'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
